evt_burst_gen: RTL and testbench

EVT_BURST_GEN -- requirements
Module: evt_burst_gen

---
 rtl/evt_pkg.sv | 16 +
 rtl/evt_period_timer.sv | 42 ++++
 rtl/evt_burst_gen.sv | 120 ++++++++++++
 tb/tb_evt_burst_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/evt_pkg.sv
// Shared definitions for the event burst generator.
//   state_e       : burst FSM state encoding
//   DEF_COUNT_W   : default width of burst length / remaining count
//   DEF_PERIOD_W  : default width of pulse spacing
package evt_pkg;

   localparam int DEF_COUNT_W  = 16;
   localparam int DEF_PERIOD_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

endpackage

// File: rtl/evt_period_timer.sv
// Gap timer for the burst generator: a down-counter reloaded on every pulse
// with the number of idle cycles that must follow it (max(period,1)-1).
//   clk_in     : clock, rising edge
//   rst_in     : synchronous active-low reset
//   load_in    : reload strobe (asserted in each pulse cycle)
//   period_in  : pulse spacing in cycles, 0 behaves as 1
//   expire_out : high in the last gap cycle, so the next cycle can pulse
module evt_period_timer #(
   parameter int PERIOD_W = 16
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                load_in,
   input  logic [PERIOD_W-1:0] period_in,
   output logic                expire_out
);

   logic [PERIOD_W-1:0] cnt_q;
   logic [PERIOD_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_in) begin
         cnt_d = (period_in == '0) ? '0 : period_in - 1'b1;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Terminal count at 1 rather than 0: the FSM needs the hint one cycle early
   // so the following pulse lands exactly one period after the previous one.
   assign expire_out = (cnt_q == PERIOD_W'(1));

endmodule

// File: rtl/evt_burst_gen.sv
// Event burst generator: on an accepted start, emits count_in one-cycle
// evt_out strobes spaced period_in cycles apart, then a done_out pulse.
//   clk_in, rst_in   : clock and synchronous active-low reset
//   start_in         : burst request, taken only while ready_out=1
//   count_in         : pulses in the burst (0 = immediate done, no pulses)
//   period_in        : cycles between pulse rising edges (0 behaves as 1)
//   abort_in         : stop the active burst without done_out
//   ready_out/busy_out : idle / burst in progress (complementary)
//   evt_out          : event strobe
//   done_out         : one-cycle normal-completion pulse
//   remaining_out    : pulses not yet emitted
//
// state | meaning
// IDLE  | waiting for start_in, ready_out=1
// PULSE | evt_out=1 this cycle, remaining count decrements
// GAP   | spacing between pulses, timed by evt_period_timer
module evt_burst_gen
   import evt_pkg::*;
#(
   parameter int COUNT_W  = DEF_COUNT_W,
   parameter int PERIOD_W = DEF_PERIOD_W
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               start_in,
   input  logic [COUNT_W-1:0] count_in,
   input  logic [PERIOD_W-1:0] period_in,
   input  logic               abort_in,
   output logic               ready_out,
   output logic               busy_out,
   output logic               evt_out,
   output logic               done_out,
   output logic [COUNT_W-1:0] remaining_out
);

   state_e              state_q;
   logic [COUNT_W-1:0]  remaining_q;
   logic [PERIOD_W-1:0] period_q;
   logic                evt_q;
   logic                done_q;
   logic                tmr_load;
   logic                tmr_expire;

   assign tmr_load = (state_q == ST_PULSE);

   evt_period_timer #(
      .PERIOD_W (PERIOD_W)
   ) u_period_timer (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .load_in    (tmr_load),
      .period_in  (period_q),
      .expire_out (tmr_expire)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         period_q    <= '0;
         evt_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         evt_q  <= 1'b0;
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start_in) begin
                  if (count_in == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     remaining_q <= count_in;
                     period_q    <= period_in;
                     state_q     <= ST_PULSE;
                     evt_q       <= 1'b1;
                  end
               end
            end
            ST_PULSE: begin
               if (abort_in) begin
                  remaining_q <= '0;
                  state_q     <= ST_IDLE;
               end else begin
                  remaining_q <= remaining_q - 1'b1;
                  if (remaining_q == COUNT_W'(1)) begin
                     state_q <= ST_IDLE;
                     done_q  <= 1'b1;
                  end else if (period_q <= PERIOD_W'(1)) begin
                     // Back-to-back pulses, no gap cycles.
                     state_q <= ST_PULSE;
                     evt_q   <= 1'b1;
                  end else begin
                     state_q <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (abort_in) begin
                  remaining_q <= '0;
                  state_q     <= ST_IDLE;
               end else if (tmr_expire) begin
                  state_q <= ST_PULSE;
                  evt_q   <= 1'b1;
               end
            end
            default: begin
               remaining_q <= '0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready_out     = (state_q == ST_IDLE);
   assign busy_out      = ~ready_out;
   assign evt_out       = evt_q;
   assign done_out      = done_q;
   assign remaining_out = remaining_q;

endmodule

// File: tb/tb_evt_burst_gen.sv
module tb_evt_burst_gen;

   localparam int BIG = 1 << 30;

   logic        clk_sys = 1'b0;
   logic        rst_in;
   logic        start_in;
   logic [15:0] count_in;
   logic [15:0] period_in;
   logic        abort_in;
   logic        ready_out, busy_out, evt_out, done_out;
   logic [15:0] remaining_out;

   logic        s_start;
   logic [3:0]  s_count, s_period, s_remaining;
   logic        s_ready, s_busy, s_evt, s_done;

   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;
   int evt_cnt = 0;
   int s_evt_n = 0;
   int s_done_n = 0;
   int exp_evt[$];
   int exp_done[$];

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   evt_burst_gen dut (
      .clk_in        (clk_sys),
      .rst_in        (rst_in),
      .start_in      (start_in),
      .count_in      (count_in),
      .period_in     (period_in),
      .abort_in      (abort_in),
      .ready_out     (ready_out),
      .busy_out      (busy_out),
      .evt_out       (evt_out),
      .done_out      (done_out),
      .remaining_out (remaining_out)
   );

   evt_burst_gen #(.COUNT_W(4), .PERIOD_W(4)) dut_s (
      .clk_in        (clk_sys),
      .rst_in        (rst_in),
      .start_in      (s_start),
      .count_in      (s_count),
      .period_in     (s_period),
      .abort_in      (1'b0),
      .ready_out     (s_ready),
      .busy_out      (s_busy),
      .evt_out       (s_evt),
      .done_out      (s_done),
      .remaining_out (s_remaining)
   );

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Scoreboard pop side: every strobe must match the head of its queue.
   always @(negedge clk_sys) begin
      if (evt_out) begin
         evt_cnt++;
         if (exp_evt.size() == 0) chk("evt_unexpected", cyc, -1);
         else chk("evt_cycle", cyc, exp_evt.pop_front());
      end
      if (done_out) begin
         if (exp_done.size() == 0) chk("done_unexpected", cyc, -1);
         else chk("done_cycle", cyc, exp_done.pop_front());
      end
      chk("busy_inv", int'(busy_out), int'(!ready_out));
      if (s_evt) s_evt_n++;
      if (s_done) s_done_n++;
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Drives one accept cycle and pushes the expected strobes. Strobes whose
   // cycle offset exceeds cut_rel are cancelled by a later abort/reset.
   task automatic launch(input int c, input int p, input int cut_rel);
      int a, pe, d;
      a  = cyc;
      pe = (p == 0) ? 1 : p;
      start_in  = 1'b1;
      count_in  = 16'(c);
      period_in = 16'(p);
      for (int k = 0; k < c; k++)
         if (k * pe + 1 <= cut_rel) exp_evt.push_back(a + 1 + k * pe);
      d = (c == 0) ? a + 1 : a + 1 + (c - 1) * pe + 1;
      if (d - a <= cut_rel) exp_done.push_back(d);
      tick();
      start_in = 1'b0;
      if (c > 0) begin
         chk("rem_first", int'(remaining_out), c);
         chk("ready_busy", int'(ready_out), 0);
      end
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 2000 && (exp_evt.size() != 0 || exp_done.size() != 0); i++) tick();
      repeat (3) tick();
      chk("drain_left", exp_evt.size() + exp_done.size(), 0);
      chk("idle_ready", int'(ready_out), 1);
      chk("idle_rem", int'(remaining_out), 0);
   endtask

   initial begin
      rst_in = 1'b0; start_in = 1'b1; abort_in = 1'b1;
      count_in = 16'd5; period_in = 16'd1;
      s_start = 1'b0; s_count = 4'd0; s_period = 4'd0;
      repeat (3) tick();
      chk("rst_ready", int'(ready_out), 1);
      chk("rst_busy", int'(busy_out), 0);
      chk("rst_evt", int'(evt_out), 0);
      chk("rst_done", int'(done_out), 0);
      chk("rst_rem", int'(remaining_out), 0);

      // First cycle out of reset accepts: count=3 period=4
      rst_in = 1'b1; abort_in = 1'b0;
      launch(3, 4, BIG);
      drain();

      // count=5 period=0 -> back-to-back
      launch(5, 0, BIG);
      drain();

      // count=0 -> done only, ready stays high
      launch(0, 7, BIG);
      chk("zero_ready0", int'(ready_out), 1);
      tick();
      chk("zero_ready1", int'(ready_out), 1);
      chk("zero_rem", int'(remaining_out), 0);
      drain();

      // count=4 period=3, abort during cycle +5
      launch(4, 3, 5);
      repeat (4) tick();
      abort_in = 1'b1;
      tick();
      abort_in = 1'b0;
      chk("abort_ready", int'(ready_out), 1);
      chk("abort_rem", int'(remaining_out), 0);
      chk("abort_done", int'(done_out), 0);
      drain();

      // abort alone in IDLE is ignored; start+abort together accepts
      abort_in = 1'b1;
      tick();
      chk("abort_idle", int'(ready_out), 1);
      launch(2, 2, BIG);
      abort_in = 1'b0;
      drain();

      // second start while busy ignored; reset during cycle +5
      launch(6, 2, 5);
      start_in = 1'b1; count_in = 16'd1; period_in = 16'd1;
      tick();
      start_in = 1'b0; count_in = 16'd9; period_in = 16'd9;
      repeat (2) tick();
      chk("busy_rem", int'(remaining_out), 4);
      tick();
      rst_in = 1'b0;
      tick();
      rst_in = 1'b1;
      chk("mid_rst_evt", int'(evt_out), 0);
      chk("mid_rst_ready", int'(ready_out), 1);
      chk("mid_rst_rem", int'(remaining_out), 0);
      drain();

      // accumulation through an event counter
      evt_cnt = 0; launch(1, 1, BIG); drain(); chk("acc_1", evt_cnt, 1);
      evt_cnt = 0; launch(7, 2, BIG); drain(); chk("acc_7", evt_cnt, 7);
      evt_cnt = 0; launch(300, 1, BIG); drain(); chk("acc_300", evt_cnt, 300);

      // maximum count on a 4-bit instance: 15 pulses, no wrap
      s_evt_n = 0; s_done_n = 0;
      s_count = 4'hF; s_period = 4'd2; s_start = 1'b1;
      tick();
      s_start = 1'b0;
      chk("max_rem_first", int'(s_remaining), 15);
      for (int i = 0; i < 200 && s_done_n == 0; i++) tick();
      repeat (3) tick();
      chk("max_pulses", s_evt_n, 15);
      chk("max_done", s_done_n, 1);
      chk("max_rem_end", int'(s_remaining), 0);
      chk("max_ready", int'(s_ready), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
